// File: rtl/morph_frame_if.sv
// Pixel-side bundle between the video source/kernel and morph_frame_ctrl.
// master drives the raster, slave is the frame controller.
interface morph_frame_if #(
  parameter int CNT_W = 12
);
  logic             in_active;
  logic             in_vsync;
  logic             kern_active;
  logic             lb_clr;
  logic [1:0]       op_mode;
  logic             flush_active;
  logic             border_mask;
  logic [CNT_W-1:0] in_col;
  logic [CNT_W-1:0] in_row;
  logic             frame_done;
  logic             busy;

  modport master (
    output in_active,
    output in_vsync,
    output kern_active,
    input  lb_clr,
    input  op_mode,
    input  flush_active,
    input  border_mask,
    input  in_col,
    input  in_row,
    input  frame_done,
    input  busy
  );

  modport slave (
    input  in_active,
    input  in_vsync,
    input  kern_active,
    output lb_clr,
    output op_mode,
    output flush_active,
    output border_mask,
    output in_col,
    output in_row,
    output frame_done,
    output busy
  );
endinterface

// File: rtl/morph_frame_ctrl.sv
// Frame sequencer for the 3x3 morphological pipeline: arms on vsync,
// latches mode, injects flush lines, builds the border mask.
module morph_frame_ctrl #(
  parameter int VIDEO_WIDTH   = 1280,
  parameter int VIDEO_HEIGHT  = 720,
  parameter int OPERATOR_SIZE = 3,
  parameter int FLUSH_HGAP    = 16,
  parameter int CNT_W         = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_enable,
  input  logic [1:0] cfg_mode,
  input  logic       err_clr,
  morph_frame_if.slave vif,
  output logic       err_len,
  output logic       err_frame,
  output logic       err_ovr
);

  localparam int K = (OPERATOR_SIZE - 1) / 2;

  localparam logic [CNT_W-1:0] W_LAST = CNT_W'(VIDEO_WIDTH - 1);
  localparam logic [CNT_W-1:0] H_END  = CNT_W'(VIDEO_HEIGHT);
  localparam logic [CNT_W-1:0] G_LAST = CNT_W'(FLUSH_HGAP - 1);
  localparam logic [CNT_W-1:0] L_LAST = CNT_W'(K - 1);
  localparam logic [CNT_W-1:0] K_LO   = CNT_W'(K);
  localparam logic [CNT_W-1:0] C_HI   = CNT_W'(VIDEO_WIDTH - K);
  localparam logic [CNT_W-1:0] R_HI   = CNT_W'(VIDEO_HEIGHT - K);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_FRAME,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic             vs_q;
  logic             vs_rise;
  logic             start;
  logic             ovr_set;
  logic             fl_end;
  logic             row_full;
  logic             len_set;
  logic             fl_ph;
  logic [CNT_W-1:0] fl_cnt;
  logic [CNT_W-1:0] fl_line;
  logic [CNT_W-1:0] col;
  logic [CNT_W-1:0] row;
  logic [CNT_W-1:0] out_col;
  logic [CNT_W-1:0] out_row;
  logic [1:0]       mode_q;
  logic             on_edge;

  // Registered rise: an edge seen at cycle t is acted on at t+1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vs_q    <= 1'b0;
      vs_rise <= 1'b0;
    end else begin
      vs_q    <= vif.in_vsync;
      vs_rise <= vif.in_vsync & ~vs_q;
    end
  end

  assign row_full = (row >= H_END);
  assign fl_end   = fl_ph && (fl_cnt == W_LAST)
                    && (fl_line == L_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    ovr_set  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (cfg_enable) state_nx = S_ARM;
      end
      S_ARM: begin
        if (!cfg_enable) begin
          state_nx = S_IDLE;
        end else if (vs_rise) begin
          start    = 1'b1;
          state_nx = S_FRAME;
        end
      end
      S_FRAME: begin
        if (row_full)     state_nx = S_FLUSH;
        else if (vs_rise) start    = 1'b1;
      end
      S_FLUSH: begin
        if (vif.in_active) begin
          ovr_set  = 1'b1;
          state_nx = S_ARM;
        end else if (fl_end) begin
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        state_nx = cfg_enable ? S_ARM : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign len_set = (state == S_FRAME) && !start && !row_full
                   && !vif.in_active && (col != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (start) begin
      col <= '0;
      row <= '0;
    end else if (state == S_FRAME && !row_full) begin
      if (vif.in_active) begin
        if (col == W_LAST) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end else if (col != '0) begin
        col <= '0;
        row <= row + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       mode_q <= 2'b00;
    else if (start) mode_q <= (cfg_mode == 2'b11) ? 2'b00 : cfg_mode;
  end

  // Each flush line: idle gap phase, then a full-width zero-pixel phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fl_ph   <= 1'b0;
      fl_cnt  <= '0;
      fl_line <= '0;
    end else if (state != S_FLUSH) begin
      fl_ph   <= 1'b0;
      fl_cnt  <= '0;
      fl_line <= '0;
    end else if (!fl_ph) begin
      if (fl_cnt == G_LAST) begin
        fl_ph  <= 1'b1;
        fl_cnt <= '0;
      end else begin
        fl_cnt <= fl_cnt + 1'b1;
      end
    end else if (fl_cnt == W_LAST) begin
      fl_ph   <= 1'b0;
      fl_cnt  <= '0;
      fl_line <= fl_line + 1'b1;
    end else begin
      fl_cnt <= fl_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_col <= '0;
      out_row <= '0;
    end else if (start) begin
      out_col <= '0;
      out_row <= '0;
    end else if (vif.kern_active) begin
      if (out_col == W_LAST) begin
        out_col <= '0;
        out_row <= out_row + 1'b1;
      end else begin
        out_col <= out_col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_len   <= 1'b0;
      err_frame <= 1'b0;
      err_ovr   <= 1'b0;
    end else begin
      err_len   <= len_set | (err_len & ~err_clr);
      err_frame <= (start && state == S_FRAME)
                   | (err_frame & ~err_clr);
      err_ovr   <= ovr_set | (err_ovr & ~err_clr);
    end
  end

  assign on_edge = (out_col < K_LO) || (out_col >= C_HI)
                   || (out_row < K_LO) || (out_row >= R_HI);

  assign vif.lb_clr       = start;
  assign vif.op_mode      = mode_q;
  assign vif.flush_active = (state == S_FLUSH) && fl_ph
                            && !vif.in_active;
  assign vif.border_mask  = rst && vif.kern_active && on_edge;
  assign vif.in_col       = col;
  assign vif.in_row       = row;
  assign vif.frame_done   = (state == S_DONE);
  assign vif.busy         = (state == S_FRAME) || (state == S_FLUSH);

endmodule

// File: doc/morph_frame_ctrl.md
Name: morph_frame_ctrl

Overview:
Frame-level sequencer for the 3x3 morphological pipeline (linebuffer -> operator window -> morph kernel).
- Tracks input raster position from active/vsync and arms the pipeline at each frame start.
- Latches the operating mode once per frame and clears the linebuffer.
- Injects zero-valued flush lines after the last input line so the bottom output rows drain.
- Generates a border mask aligned to the kernel output, and reports raster errors through sticky flags.

Parameters:
VIDEO_WIDTH, 1280, active pixels per line
VIDEO_HEIGHT, 720, active lines per frame
OPERATOR_SIZE, 3, kernel size, odd >= 3; K = (OPERATOR_SIZE-1)/2
FLUSH_HGAP, 16, idle cycles before each flush line
CNT_W, 12, row/column counter width; must hold max(VIDEO_WIDTH, VIDEO_HEIGHT+K)

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous, active-low reset
cfg_enable  in  1  1 = controller runs; 0 = return to IDLE at the next DONE or immediately when in ARM
cfg_mode  in  2  00 bypass, 01 erode, 10 dilate, 11 treated as bypass
err_clr  in  1  synchronous clear of sticky error flags
in_active  in  1  input pixel valid
in_vsync  in  1  input vsync, active-high
kern_active  in  1  pipeline output valid (kernel out_valid)
lb_clr  out  1  one-cycle synchronous clear to linebuffer/operator
op_mode  out  2  per-frame latched mode to the kernel mux
flush_active  out  1  select zero pixel into linebuffer input and force its valid high
border_mask  out  1  current kern_active pixel lies within K of the frame edge
in_col  out  CNT_W  input column counter
in_row  out  CNT_W  input row counter
frame_done  out  1  one-cycle pulse when flush completes
busy  out  1  state is FRAME or FLUSH
err_len  out  1  sticky: line ended with col != VIDEO_WIDTH
err_frame  out  1  sticky: vsync rose before VIDEO_HEIGHT lines
err_ovr  out  1  sticky: in_active asserted during FLUSH

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; counters 0; op_mode 00.
- vsync rise: detected with one register stage. An edge at cycle t acts at t+1.
- IDLE: when cfg_enable=1, go to ARM.
- ARM:
  - When cfg_enable=0, go to IDLE.
  - On vsync rise: latch op_mode from cfg_mode, pulse lb_clr for 1 cycle, zero all counters, go to FRAME.
- FRAME:
  - Each in_active cycle: in_col++.
  - When in_active and in_col == VIDEO_WIDTH-1: in_col <- 0, in_row++.
  - in_active falls with in_col != 0: set err_len, in_col <- 0, in_row++.
  - When in_row reaches VIDEO_HEIGHT: go to FLUSH.
  - vsync rise while in_row < VIDEO_HEIGHT: set err_frame, then restart exactly as in ARM (relatch mode, lb_clr, counters 0).
- FLUSH: K lines, each one FLUSH_HGAP idle cycles followed by VIDEO_WIDTH cycles of flush_active=1.
  - in_active=1 in any FLUSH cycle: drop flush_active the same cycle (combinational gate), set err_ovr, go to ARM. No frame_done in this case.
  - Flush completes: go to DONE.
- DONE: frame_done=1 for one cycle, then ARM if cfg_enable=1, else IDLE.
- op_mode is stable for the whole frame. cfg_mode changes mid-frame have no effect until the next vsync rise.
- Output side:
  - out_col and out_row advance on kern_active with the same wrap rule as the input counters; they are zeroed by lb_clr.
  - border_mask is combinational from out_col/out_row and is valid in the same cycle as kern_active.
  - border_mask = kern_active & (out_col < K | out_col >= VIDEO_WIDTH-K | out_row < K | out_row >= VIDEO_HEIGHT-K).
  - border_mask is 0 whenever kern_active=0.
- Error flags: set-dominant. When err_clr and a set condition occur in the same cycle, the flag stays 1.
- cfg_enable dropped during FRAME/FLUSH: the current frame completes; the controller then goes to IDLE from DONE.
- Reset mid-frame: immediate return to IDLE with all outputs 0. lb_clr is not pulsed.

Test Plan:
- Nominal frame, W=8, H=4, K=1, HGAP=2, mode=01: vsync rise -> lb_clr pulse 1 cycle later, op_mode=01; 4 lines of 8 -> 1 flush line of 8 flush_active cycles after 2 idle cycles; frame_done pulse; no errors.
- Mode change mid-frame: cfg_mode 01->10 at line 2 -> op_mode stays 01 to frame end; becomes 10 at next vsync rise.
- Short line: 6 active pixels then in_active low -> err_len=1, in_col=0, in_row incremented; err_clr pulse -> err_len=0.
- Early vsync after 2 of 4 lines -> err_frame=1, second lb_clr pulse, counters 0, state FRAME.
- in_active asserted at cycle 3 of the flush line -> flush_active=0 that cycle, err_ovr=1, no frame_done, state ARM.
- Border mask, W=8, H=4, kern_active driving 32 pixels -> mask=1 for rows 0 and 3 and cols 0 and 7 (20 pixels), 0 for the 12 interior pixels; async reset mid-frame -> all outputs 0 within the reset cycle.
